// File: rtl/mmio_pkg.sv
// Shared constants for the MIPS data-side MMIO responder: I/O register
// offsets, CTRL/STATUS bit positions and the default I/O window base.
package mmio_pkg;

  localparam logic [31:0] IO_BASE_DEFAULT = 32'hFFFF_0000;

  // Byte offsets inside the I/O window
  localparam logic [7:0] OFF_CTRL     = 8'h00;
  localparam logic [7:0] OFF_COUNT    = 8'h04;
  localparam logic [7:0] OFF_CMP      = 8'h08;
  localparam logic [7:0] OFF_STATUS   = 8'h0C;
  localparam logic [7:0] OFF_GPIO_OUT = 8'h10;
  localparam logic [7:0] OFF_GPIO_IN  = 8'h14;

  // CTRL bit indices
  localparam int unsigned CTRL_EN         = 0;
  localparam int unsigned CTRL_AUTORELOAD = 1;
  localparam int unsigned CTRL_IRQEN      = 2;
  localparam int unsigned CTRL_W          = 3;

  // STATUS bit index
  localparam int unsigned STAT_MATCH = 0;

endpackage

// File: rtl/mmio_timer.sv
// Prescaled timer with compare match: owns CTRL, COUNT, CMP, STATUS and irq.
// Ports:
//   clk, reset      - clock, asynchronous active-low reset
//   wr_ctrl/count/cmp/status - decoded single-cycle write strobes
//   wdata           - CPU store data
//   rd_word         - word offset (address bits [7:2]) for the read mux
//   rdata_c         - combinational read data, 0 for offsets not owned here
//   irq             - registered MATCH & IRQEN
module mmio_timer
  import mmio_pkg::*;
#(
  parameter int unsigned PRESCALE = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_ctrl,
  input  logic        wr_count,
  input  logic        wr_cmp,
  input  logic        wr_status,
  input  logic [31:0] wdata,
  input  logic [5:0]  rd_word,
  output logic [31:0] rdata_c,
  output logic        irq
);

  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [31:0]       count_q, count_d;
  logic [31:0]       cmp_q, cmp_d;
  logic              match_q, match_d;
  logic [PW-1:0]     pre_q, pre_d;
  logic              irq_d;
  logic              tick_c;

  assign tick_c = ctrl_q[CTRL_EN] && (pre_q == PRE_LAST);

  // Next-state: timer events first, CPU writes override afterwards
  always_comb begin
    ctrl_d  = ctrl_q;
    count_d = count_q;
    cmp_d   = cmp_q;
    match_d = match_q;
    pre_d   = pre_q;

    if (!ctrl_q[CTRL_EN] || tick_c) pre_d = '0;
    else                            pre_d = pre_q + PW'(1);

    // W1C is applied before the tick so a same-edge match still sets
    if (wr_status && wdata[STAT_MATCH]) match_d = 1'b0;

    if (tick_c) begin
      if (count_q == cmp_q) begin
        match_d = 1'b1;
        if (ctrl_q[CTRL_AUTORELOAD]) begin
          count_d = '0;
        end else begin
          count_d = count_q + 32'd1;
          ctrl_d[CTRL_EN] = 1'b0;
        end
      end else begin
        count_d = count_q + 32'd1;
      end
    end

    if (wr_ctrl) begin
      ctrl_d = wdata[CTRL_W-1:0];
      if (!wdata[CTRL_EN]) pre_d = '0;
    end
    if (wr_count) count_d = wdata;
    if (wr_cmp)   cmp_d   = wdata;

    irq_d = match_d & ctrl_d[CTRL_IRQEN];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrl_q  <= '0;
      count_q <= '0;
      cmp_q   <= '0;
      match_q <= 1'b0;
      pre_q   <= '0;
      irq     <= 1'b0;
    end else begin
      ctrl_q  <= ctrl_d;
      count_q <= count_d;
      cmp_q   <= cmp_d;
      match_q <= match_d;
      pre_q   <= pre_d;
      irq     <= irq_d;
    end
  end

  // Register read mux
  always_comb begin
    rdata_c = '0;
    case (rd_word)
      OFF_CTRL[7:2]:   rdata_c = 32'(ctrl_q);
      OFF_COUNT[7:2]:  rdata_c = count_q;
      OFF_CMP[7:2]:    rdata_c = cmp_q;
      OFF_STATUS[7:2]: rdata_c = 32'(match_q);
      default:         rdata_c = '0;
    endcase
  end

endmodule

// File: rtl/mips_mmio_responder.sv
// Data-side responder for the single-cycle MIPS core: word-addressed data RAM
// plus an I/O window (timer, optional GPIO). Loads are combinational, stores
// and all register updates happen on the rising clock edge.
// Optional GPIO is built when MMIO_GPIO_EN is defined; otherwise offsets
// 0x10/0x14 read 0, gpio_out is tied low and gpio_in is ignored.
// Ports:
//   clk, reset          - clock, asynchronous active-low reset
//   memwrite            - store strobe
//   memaddr             - byte address
//   memwritedata        - store data
//   memreaddata         - combinational load data
//   irq                 - registered timer interrupt
//   gpio_in, gpio_out   - external GPIO (gpio_out registered)
module mips_mmio_responder
  import mmio_pkg::*;
#(
  parameter int unsigned RAM_WORDS = 64,
  parameter logic [31:0] IO_BASE   = IO_BASE_DEFAULT,
  parameter int unsigned PRESCALE  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memwrite,
  input  logic [31:0] memaddr,
  input  logic [31:0] memwritedata,
  output logic [31:0] memreaddata,
  output logic        irq,
  input  logic [15:0] gpio_in,
  output logic [15:0] gpio_out
);

  localparam int unsigned AW = $clog2(RAM_WORDS);

  logic [31:0]   ram [RAM_WORDS];
  logic          ram_hit_c;
  logic          io_hit_c;
  logic          gpio_hit_c;
  logic [AW-1:0] ram_idx_c;
  logic [5:0]    io_word_c;
  logic          io_we_c;
  logic [31:0]   timer_rdata_c;
  logic [31:0]   gpio_rdata_c;

  // Address decode; byte-lane bits [1:0] never participate
  assign ram_hit_c  = (memaddr[31:AW+2] == '0);
  assign io_hit_c   = (memaddr[31:8] == IO_BASE[31:8]);
  assign ram_idx_c  = memaddr[AW+1:2];
  assign io_word_c  = memaddr[7:2];
  assign io_we_c    = memwrite && io_hit_c;
  assign gpio_hit_c = io_hit_c && ((io_word_c == OFF_GPIO_OUT[7:2]) ||
                                   (io_word_c == OFF_GPIO_IN[7:2]));

  // Data RAM: synchronous write, asynchronous read, contents not reset
  always_ff @(posedge clk) begin
    if (memwrite && ram_hit_c) ram[ram_idx_c] <= memwritedata;
  end

  mmio_timer #(
    .PRESCALE (PRESCALE)
  ) u_timer (
    .clk       (clk),
    .reset     (reset),
    .wr_ctrl   (io_we_c && (io_word_c == OFF_CTRL[7:2])),
    .wr_count  (io_we_c && (io_word_c == OFF_COUNT[7:2])),
    .wr_cmp    (io_we_c && (io_word_c == OFF_CMP[7:2])),
    .wr_status (io_we_c && (io_word_c == OFF_STATUS[7:2])),
    .wdata     (memwritedata),
    .rd_word   (io_word_c),
    .rdata_c   (timer_rdata_c),
    .irq       (irq)
  );

`ifdef MMIO_GPIO_EN
  logic [15:0] gpio_sync1;
  logic [15:0] gpio_sync2;

  // GPIO output register and two-flop input synchronizer
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gpio_out   <= '0;
      gpio_sync1 <= '0;
      gpio_sync2 <= '0;
    end else begin
      if (io_we_c && (io_word_c == OFF_GPIO_OUT[7:2])) gpio_out <= memwritedata[15:0];
      gpio_sync1 <= gpio_in;
      gpio_sync2 <= gpio_sync1;
    end
  end

  always_comb begin
    gpio_rdata_c = '0;
    if (io_word_c == OFF_GPIO_OUT[7:2]) gpio_rdata_c = 32'(gpio_out);
    else if (io_word_c == OFF_GPIO_IN[7:2]) gpio_rdata_c = 32'(gpio_sync2);
  end
`else
  logic unused_gpio_in;

  assign unused_gpio_in = ^gpio_in;
  assign gpio_out       = '0;
  assign gpio_rdata_c   = '0;
`endif

  // Load data mux; unmapped addresses read 0
  always_comb begin
    memreaddata = '0;
    if (ram_hit_c)       memreaddata = ram[ram_idx_c];
    else if (gpio_hit_c) memreaddata = gpio_rdata_c;
    else if (io_hit_c)   memreaddata = timer_rdata_c;
  end

endmodule
